id_stage: RTL
=============

Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage RV32I pipeline.
- Takes the IF/ID instruction and PC, and drives the register-file read addresses.
- Decodes control and immediate, detects load-use hazards, and registers everything into the ID/EX pipeline register consumed by the execute stage.
- Register file writes on negedge clk, so read data is settled before the posedge capture; no WB-to-ID bypass exists in this block.

Parameters:
- XLEN, 32, datapath width.
- FLUSH_ON_ILLEGAL, 1, when 1 an illegal opcode enters ID/EX as a bubble with ex_illegal=1.

Ports:
- clk  in  1  pipeline clock, all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- if_id_valid  in  1  IF/ID holds a real instruction.
- if_id_instr  in  32  instruction word.
- if_id_pc  in  XLEN  instruction PC.
- rf_a1  out  5  register file read address 1, combinational = instr[19:15].
- rf_a2  out  5  register file read address 2, combinational = instr[24:20].
- rf_rd1  in  XLEN  register file read data 1.
- rf_rd2  in  XLEN  register file read data 2.
- ex_flush  in  1  branch/jump redirect resolved in EX this cycle.
- stall_if  out  1  hold PC and IF/ID, combinational.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_pc  out  XLEN  PC of the instruction.
- ex_rs1_data  out  XLEN  rs1 operand.
- ex_rs2_data  out  XLEN  rs2 operand.
- ex_imm  out  XLEN  sign-extended immediate.
- ex_rs1  out  5  source register index, for forwarding.
- ex_rs2  out  5  source register index, for forwarding.
- ex_rd  out  5  destination register index.
- ex_funct3  out  3  funct3 field.
- ex_alu_ctrl  out  4  ALU operation code.
- ex_alu_src  out  1  ALU operand B select: 1 = immediate.
- ex_mem_read  out  1  load.
- ex_mem_write  out  1  store.
- ex_reg_write  out  1  writes rd.
- ex_result_src  out  2  writeback select: 0 ALU, 1 memory, 2 PC+4.
- ex_branch  out  1  conditional branch.
- ex_jump  out  1  JAL or JALR.
- ex_illegal  out  1  unsupported opcode.

Behaviour:
- Reset (rst=0, asynchronous): every ex_* output is 0. stall_if follows its equation with ex_valid=0, so it is 0.
- Latency: one cycle. Fields decoded from IF/ID in cycle N appear on ex_* after posedge N+1.
- Opcodes supported: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP. Anything else is illegal.
- Immediate formats: I, S, B, U, J.
  - I, S, B and J immediates are sign-extended from instr[31].
  - U immediate is instr[31:12] followed by 12 zeros.
  - B and J immediates have bit 0 equal to 0.
- Source usage:
  - rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
  - rs2 is used by BRANCH, STORE and OP.
  - An unused source reports index 0 on ex_rs1/ex_rs2.
- ex_reg_write is 0 whenever rd=0.
- Load-use hazard:
  - Condition: hz = if_id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((rs1 used & rs1==ex_rd) | (rs2 used & rs2==ex_rd)).
  - stall_if = hz & ~ex_flush.
  - While hz: at posedge a bubble is loaded (ex_valid=0, all control 0, data fields don't-care but held at 0).
- Flush: ex_flush=1 at posedge loads a bubble. Flush has priority over stall, and stall_if is forced to 0 during flush.
- Invalid input: if_id_valid=0 loads a bubble.
- Illegal opcode:
  - FLUSH_ON_ILLEGAL=1: ex_illegal=1 and ex_valid=0, with all control 0.
  - FLUSH_ON_ILLEGAL=0: ex_valid=1, ex_illegal=1, and all control 0.
- Consecutive stalls: after one bubble, ex_mem_read=0, so hz deasserts. A load-use stall therefore lasts exactly one cycle.
- Simultaneous flush + hazard → bubble, stall_if=0.
- Reset mid-stall → bubble state immediately, with no glitching dependence on clk.

Decomposition:
- Package rv_pkg holds:
  - opcode constants (OPC_LUI … OPC_OP);
  - ALU_* 4-bit codes (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, LUI_PASS);
  - RES_ALU/RES_MEM/RES_PC4 encodings.
- One sub-module, id_decoder: purely combinational. It maps the instruction to control, immediate and use flags.
- id_stage holds the hazard logic and the ID/EX registers.

Test Plan:
1. Reset then release; IF/ID = ADDI x5,x0,-1 (0xFFF00293), pc=0x100 → next edge: ex_valid=1, ex_imm=0xFFFFFFFF, ex_rd=5, ex_alu_src=1, ex_reg_write=1, ex_alu_ctrl=ALU_ADD.
2. LW x6,0(x1) followed by ADD x7,x6,x2 → stall_if=1 for exactly one cycle, one bubble (ex_valid=0) observed, then ADD enters with ex_rs1=6.
3. LW x6,0(x1) followed by ADD x7,x0,x0 (no dependence), and LW x0 followed by a user of x0 → no stall.
4. Load-use hazard with ex_flush=1 in the same cycle → stall_if=0, bubble loaded, ex_valid=0.
5. Immediate check:
   - BEQ with offset −4 (0xFE000EE3) → ex_imm=0xFFFFFFFC, ex_branch=1, ex_reg_write=0.
   - JAL x1,+2048 → ex_imm=0x00000800, ex_result_src=2.
   - LUI 0x12345 → ex_imm=0x12345000.
6. Opcode 0x7F with FLUSH_ON_ILLEGAL=1 → ex_illegal=1, ex_valid=0. Also assert rst low mid-stream → all ex_* go to 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I decode constants and the control bundle carried from ID into EX.
package rv_pkg;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD      = 4'd0;
  localparam logic [3:0] ALU_SUB      = 4'd1;
  localparam logic [3:0] ALU_SLL      = 4'd2;
  localparam logic [3:0] ALU_SLT      = 4'd3;
  localparam logic [3:0] ALU_SLTU     = 4'd4;
  localparam logic [3:0] ALU_XOR      = 4'd5;
  localparam logic [3:0] ALU_SRL      = 4'd6;
  localparam logic [3:0] ALU_SRA      = 4'd7;
  localparam logic [3:0] ALU_OR       = 4'd8;
  localparam logic [3:0] ALU_AND      = 4'd9;
  localparam logic [3:0] ALU_LUI_PASS = 4'd10;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic       branch;
    logic       jump;
  } ctrl_t;

  // alt selects SUB over ADD and SRA over SRL (instr[30]).
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/id_decoder.sv
// Combinational RV32I decoder: control bundle, immediate and register-usage flags.
module id_decoder
  import rv_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic [31:0] imm,
  output logic        use_rs1,
  output logic        use_rs2,
  output logic        has_rd,
  output logic        illegal
);
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    ctrl    = '0;
    imm     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    has_rd  = 1'b0;
    illegal = 1'b0;
    case (instr[6:0])
      OPC_LUI: begin
        imm = imm_u; ctrl.alu_ctrl = ALU_LUI_PASS; ctrl.alu_src = 1'b1; has_rd = 1'b1;
      end
      OPC_AUIPC: begin
        imm = imm_u; ctrl.alu_src = 1'b1; has_rd = 1'b1;
      end
      OPC_JAL: begin
        imm = imm_j; ctrl.alu_src = 1'b1; ctrl.result_src = RES_PC4; ctrl.jump = 1'b1; has_rd = 1'b1;
      end
      OPC_JALR: begin
        imm = imm_i; ctrl.alu_src = 1'b1; ctrl.result_src = RES_PC4; ctrl.jump = 1'b1;
        has_rd = 1'b1; use_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        imm = imm_b; ctrl.alu_ctrl = ALU_SUB; ctrl.branch = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        imm = imm_i; ctrl.alu_src = 1'b1; ctrl.mem_read = 1'b1; ctrl.result_src = RES_MEM;
        has_rd = 1'b1; use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        imm = imm_s; ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        // Only the shift-right immediate uses instr[30]; ADDI has no subtract form.
        imm = imm_i; ctrl.alu_src = 1'b1; has_rd = 1'b1; use_rs1 = 1'b1;
        ctrl.alu_ctrl = alu_from_f3(instr[14:12], instr[30] & (instr[14:12] == 3'd5));
      end
      OPC_OP: begin
        ctrl.alu_ctrl = alu_from_f3(instr[14:12], instr[30]);
        has_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    ctrl.reg_write = has_rd & (instr[11:7] != 5'd0);
  end
endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register-file addressing, load-use hazard detection and the ID/EX register.
module id_stage
  import rv_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter bit FLUSH_ON_ILLEGAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_id_valid,
  input  logic [31:0]     if_id_instr,
  input  logic [XLEN-1:0] if_id_pc,
  output logic [4:0]      rf_a1,
  output logic [4:0]      rf_a2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            ex_flush,
  output logic            stall_if,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic [3:0]      ex_alu_ctrl,
  output logic            ex_alu_src,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic [1:0]      ex_result_src,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_illegal
);
  ctrl_t       dec_ctrl;
  logic [31:0] dec_imm;
  logic        use_rs1, use_rs2, has_rd, dec_illegal;
  logic        hz, accept, bubble;

  id_decoder u_dec (
    .instr   (if_id_instr),
    .ctrl    (dec_ctrl),
    .imm     (dec_imm),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2),
    .has_rd  (has_rd),
    .illegal (dec_illegal)
  );

  assign rf_a1 = if_id_instr[19:15];
  assign rf_a2 = if_id_instr[24:20];

  assign hz = if_id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
              ((use_rs1 & (rf_a1 == ex_rd)) | (use_rs2 & (rf_a2 == ex_rd)));
  assign stall_if = hz & ~ex_flush;
  assign accept   = if_id_valid & ~ex_flush & ~hz;
  assign bubble   = ~accept | (dec_illegal & FLUSH_ON_ILLEGAL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || bubble) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_rs1_data   <= '0;
      ex_rs2_data   <= '0;
      ex_imm        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_funct3     <= '0;
      ex_alu_ctrl   <= '0;
      ex_alu_src    <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_result_src <= '0;
      ex_branch     <= 1'b0;
      ex_jump       <= 1'b0;
      // A flushed-on-illegal instruction still reports itself as the bubble's cause.
      ex_illegal    <= rst & accept & dec_illegal;
    end else begin
      ex_valid      <= 1'b1;
      ex_pc         <= if_id_pc;
      ex_rs1_data   <= rf_rd1;
      ex_rs2_data   <= rf_rd2;
      ex_imm        <= XLEN'($signed(dec_imm));
      ex_rs1        <= use_rs1 ? rf_a1 : 5'd0;
      ex_rs2        <= use_rs2 ? rf_a2 : 5'd0;
      ex_rd         <= has_rd ? if_id_instr[11:7] : 5'd0;
      ex_funct3     <= dec_illegal ? 3'd0 : if_id_instr[14:12];
      ex_alu_ctrl   <= dec_ctrl.alu_ctrl;
      ex_alu_src    <= dec_ctrl.alu_src;
      ex_mem_read   <= dec_ctrl.mem_read;
      ex_mem_write  <= dec_ctrl.mem_write;
      ex_reg_write  <= dec_ctrl.reg_write;
      ex_result_src <= dec_ctrl.result_src;
      ex_branch     <= dec_ctrl.branch;
      ex_jump       <= dec_ctrl.jump;
      ex_illegal    <= dec_illegal;
    end
  end
endmodule
